// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM stage: pipeline-bus field positions and FSM encoding.
// Field positions match what the EX stage drives and what writeback_stage consumes.
package memory_stage_pkg;

    localparam int BUS_W     = 58;
    localparam int DATA_W    = 16;
    localparam int STORE_LSB = 26;
    localparam int ALU_LSB   = 10;
    localparam int MEMRD_BIT = 6;
    localparam int POP_BIT   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Bus bits [6:3] in order MemRd, MemWr, Push, Pop.
    typedef struct packed {
        logic memrd;
        logic memwr;
        logic push;
        logic pop;
    } mem_ops_t;

    function automatic logic [BUS_W-1:0] with_data(input logic [BUS_W-1:0] bus,
                                                   input logic [DATA_W-1:0] data);
        logic [BUS_W-1:0] r;
        r = bus;
        r[STORE_LSB +: DATA_W] = data;
        return r;
    endfunction

endpackage

// File: rtl/memory_stage_stack_pointer_unit.sv
// Stack pointer register with push/pop address generation and wrap detection.
// SP only moves when an access commits, so the address stays valid for the whole access.
module stack_pointer_unit #(
    parameter int               ADDR_W   = 11,
    parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              commit,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] stack_addr,
    output logic              wrap
);

    logic [ADDR_W-1:0] sp_inc;
    logic [ADDR_W-1:0] sp_dec;

    assign sp_inc     = sp + ADDR_W'(1);
    assign sp_dec     = sp - ADDR_W'(1);
    // Push writes at SP then decrements; pop pre-increments and reads there.
    assign stack_addr = push ? sp : sp_inc;
    assign wrap       = (push && (sp == '0)) || (pop && (sp == '1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= SP_RESET;
        end else if (commit) begin
            if (push)
                sp <= sp_dec;
            else if (pop)
                sp <= sp_inc;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: load/store/push/pop against a ready-handshake data memory,
// upstream stall while an access is outstanding, and the MEM/WB register.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int               ADDR_W   = 11,
    parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BUS_W-1:0]  in_bus,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              out_valid,
    output logic [BUS_W-1:0]  out_bus,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_err
);

    state_t            state;
    logic [BUS_W-1:0]  hold_bus_p1;
    mem_ops_t          in_ops;
    mem_ops_t          hold_ops;
    mem_ops_t          cur_ops;
    logic              accept;
    logic              commit;
    logic              illegal;
    logic              in_write;
    logic              hold_read;
    logic [ADDR_W-1:0] stack_addr;
    logic              wrap;

    assign in_ops    = in_bus[MEMRD_BIT:POP_BIT];
    assign hold_ops  = hold_bus_p1[MEMRD_BIT:POP_BIT];
    assign cur_ops   = (state == IDLE) ? in_ops : hold_ops;
    assign accept    = (state == IDLE) && in_valid && $onehot(in_ops);
    assign illegal   = (state == IDLE) && in_valid && !$onehot0(in_ops);
    assign commit    = (state == WAIT) && mem_ready;
    assign in_write  = in_ops.memwr || in_ops.push;
    assign hold_read = hold_ops.memrd || hold_ops.pop;
    assign stall     = (state != IDLE);

    stack_pointer_unit #(
        .ADDR_W   (ADDR_W),
        .SP_RESET (SP_RESET)
    ) u_sp (
        .clk        (clk),
        .rst        (rst),
        .push       (cur_ops.push),
        .pop        (cur_ops.pop),
        .commit     (commit),
        .sp         (sp),
        .stack_addr (stack_addr),
        .wrap       (wrap)
    );

    // Accept -> hold: instruction captured for the duration of the access
    always_ff @(posedge clk) begin
        if (accept)
            hold_bus_p1 <= in_bus;
    end

    // Control and MEM/WB register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            out_valid <= 1'b0;
            out_bus   <= '0;
            stack_err <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                state     <= WAIT;
                mem_req   <= 1'b1;
                mem_we    <= in_write;
                mem_addr  <= (in_ops.push || in_ops.pop) ? stack_addr
                                                         : in_bus[ALU_LSB +: ADDR_W];
                mem_wdata <= in_write ? in_bus[STORE_LSB +: DATA_W] : '0;
                out_valid <= 1'b0;
                out_bus   <= '0;
            end else begin
                out_valid <= in_valid;
                out_bus   <= in_valid ? with_data(in_bus, '0) : '0;
                if (illegal)
                    stack_err <= 1'b1;
            end
        end else begin
            if (mem_ready) begin
                state     <= IDLE;
                mem_req   <= 1'b0;
                out_valid <= 1'b1;
                out_bus   <= with_data(hold_bus_p1, hold_read ? mem_rdata : '0);
                if (wrap)
                    stack_err <= 1'b1;
            end else begin
                out_valid <= 1'b0;
                out_bus   <= '0;
            end
        end
    end

endmodule
